// File: rtl/i2c_byte_ctl_pkg.sv
// Shared definitions for the I2C byte sequencer: bit-engine command
// encodings, byte-FSM states, the captured request record and small
// helpers that decide sequencing order.
package i2c_byte_ctl_pkg;

  // Commands understood by the i2c_bit_ctl bit engine
  typedef enum logic [2:0] {
    CMD_IDLE   = 3'd0,
    CMD_START  = 3'd1,
    CMD_STOP   = 3'd2,
    CMD_WRITE  = 3'd3,
    CMD_READ   = 3'd4,
    CMD_WR_ACK = 3'd5,
    CMD_RD_ACK = 3'd6
  } bit_cmd_e;

  // Byte-level sequencer states
  typedef enum logic [2:0] {
    BY_IDLE  = 3'd0,
    BY_START = 3'd1,
    BY_WRITE = 3'd2,
    BY_READ  = 3'd3,
    BY_ACK   = 3'd4,
    BY_STOP  = 3'd5
  } byte_state_e;

  // Request flags frozen when go is accepted
  typedef struct packed {
    logic sta;
    logic sto;
    logic rd;
    logic wr;
    logic ackIn;
  } byte_req_t;

  // Picks the next phase of a request; once START is done it is skipped.
  // Write wins over read, STOP always comes last, BY_IDLE means finished.
  function automatic byte_state_e nextPhase(byte_req_t req, logic afterStart);
    byte_state_e s;
    s = BY_IDLE;
    if (req.sta && !afterStart) s = BY_START;
    else if (req.wr)            s = BY_WRITE;
    else if (req.rd)            s = BY_READ;
    else if (req.sto)           s = BY_STOP;
    return s;
  endfunction

  // Bit-engine command issued while sitting in a given state. The ACK
  // phase reads the slave ACK after a write and drives ours after a read.
  function automatic bit_cmd_e cmdForState(byte_state_e s, logic afterWrite);
    bit_cmd_e c;
    c = CMD_IDLE;
    case (s)
      BY_START: c = CMD_START;
      BY_WRITE: c = CMD_WRITE;
      BY_READ:  c = CMD_READ;
      BY_ACK:   c = afterWrite ? CMD_RD_ACK : CMD_WR_ACK;
      BY_STOP:  c = CMD_STOP;
      default:  c = CMD_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_byte_ctl_if.sv
// Host-side request/response signals plus the bit-engine command
// handshake of the I2C byte sequencer, bundled as one interface.
interface i2c_byte_ctl_if #(parameter int DW = 8) ();

  logic          enable;
  logic          go;
  logic          sta;
  logic          sto;
  logic          rd;
  logic          wr;
  logic          ack_in;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] rx_data;
  logic          rx_ack;
  logic          done;
  logic          busy;
  logic          arb_lost;
  logic [2:0]    bit_cmd;
  logic          bit_ack;
  logic          bit_din;
  logic          bit_dout;
  logic          bit_arblost;

  // View of the byte sequencer itself
  modport master (
    input  enable, go, sta, sto, rd, wr, ack_in, tx_data,
    input  bit_ack, bit_dout, bit_arblost,
    output rx_data, rx_ack, done, busy, arb_lost, bit_cmd, bit_din
  );

  // View of the host and bit engine surrounding the sequencer
  modport slave (
    output enable, go, sta, sto, rd, wr, ack_in, tx_data,
    output bit_ack, bit_dout, bit_arblost,
    input  rx_data, rx_ack, done, busy, arb_lost, bit_cmd, bit_din
  );

endinterface

// File: rtl/i2c_byte_ctl.sv
// I2C byte sequencer: splits one START/WRITE/READ/ACK/STOP request into
// per-bit commands for the bit engine, shifting data MSB-first, and
// reports the received byte, slave ACK and a one-cycle done pulse.
module i2c_byte_ctl
  import i2c_byte_ctl_pkg::*;
#(
  parameter int DW = 8
) (
  input logic            sysclk,
  input logic            nReset,
  i2c_byte_ctl_if.master bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  byte_state_e   state_q,  state_d;
  bit_cmd_e      bitCmd_q, bitCmd_d;
  logic          bitDin_q, bitDin_d;
  logic [DW-1:0] shift_q,  shift_d;
  logic [DW-1:0] rxData_q, rxData_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          rxAck_q,  rxAck_d;
  logic          done_q,   done_d;
  logic          busy_q,   busy_d;
  logic          arbLost_q, arbLost_d;
  byte_req_t     req_q,    req_d;

  // Next state plus the registered bit command/data for the state entered
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    rxData_d  = rxData_q;
    rxAck_d   = rxAck_q;
    arbLost_d = arbLost_q;
    req_d     = req_q;
    bitCmd_d  = CMD_IDLE;
    bitDin_d  = 1'b1;
    done_d    = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      BY_IDLE: begin
        if (bus.go) begin
          req_d     = {bus.sta, bus.sto, bus.rd, bus.wr, bus.ack_in};
          shift_d   = bus.tx_data;
          cnt_d     = CW'(DW - 1);
          arbLost_d = 1'b0;
          state_d   = nextPhase(req_d, 1'b0);
        end
      end
      default: begin
        if (bus.bit_arblost) begin
          arbLost_d = 1'b1;
          state_d   = BY_IDLE;
        end else if (bus.bit_ack) begin
          case (state_q)
            BY_START: state_d = nextPhase(req_q, 1'b1);
            BY_WRITE, BY_READ: begin
              shift_d = {shift_q[DW-2:0], (state_q == BY_READ) ? bus.bit_dout : 1'b0};
              if (cnt_q == '0) state_d = BY_ACK;
              else             cnt_d   = cnt_q - CW'(1);
            end
            BY_ACK: begin
              if (req_q.wr) rxAck_d  = bus.bit_dout;
              else          rxData_d = shift_q;
              state_d = req_q.sto ? BY_STOP : BY_IDLE;
            end
            default: state_d = BY_IDLE;
          endcase
        end
      end
    endcase

    busy_d   = (state_d != BY_IDLE);
    done_d   = (state_d == BY_IDLE) && ((state_q != BY_IDLE) || bus.go);
    bitCmd_d = cmdForState(state_d, req_d.wr);
    case (state_d)
      BY_WRITE: bitDin_d = shift_d[DW-1];
      BY_ACK:   bitDin_d = req_d.wr ? 1'b1 : req_d.ackIn;
      default:  bitDin_d = 1'b1;
    endcase

    if (!bus.enable) begin
      state_d   = BY_IDLE;
      bitCmd_d  = CMD_IDLE;
      bitDin_d  = 1'b1;
      shift_d   = '0;
      cnt_d     = '0;
      rxData_d  = '0;
      rxAck_d   = 1'b1;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      arbLost_d = 1'b0;
      req_d     = '0;
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge sysclk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= BY_IDLE;
      bitCmd_q  <= CMD_IDLE;
      bitDin_q  <= 1'b1;
      shift_q   <= '0;
      cnt_q     <= '0;
      rxData_q  <= '0;
      rxAck_q   <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      arbLost_q <= 1'b0;
      req_q     <= '0;
    end else begin
      state_q   <= state_d;
      bitCmd_q  <= bitCmd_d;
      bitDin_q  <= bitDin_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      rxData_q  <= rxData_d;
      rxAck_q   <= rxAck_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      arbLost_q <= arbLost_d;
      req_q     <= req_d;
    end
  end

  assign bus.rx_data  = rxData_q;
  assign bus.rx_ack   = rxAck_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.arb_lost = arbLost_q;
  assign bus.bit_cmd  = bitCmd_q;
  assign bus.bit_din  = bitDin_q;

endmodule
